// File: rtl/cmp_arb.sv
// cmp_arb: round-robin arbiter sharing one 15-bit unsigned magnitude comparator among NUM_REQ requesters.
// Define CMP_ARB_STATS_EN to add the saturating cmp_cnt transaction counter output.
module mag15 (
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic        gt,
  output logic        eq,
  output logic        lt
);
  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;
endmodule

module cmp_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 15,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] opA,
  input  logic [NUM_REQ*WIDTH-1:0] opB,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic                     vld,
  output logic [IDW-1:0]           rsp_id,
`ifdef CMP_ARB_STATS_EN
  output logic [15:0]              cmp_cnt,
`endif
  output logic                     AgtB,
  output logic                     AeqB,
  output logic                     AltB
);
  if (WIDTH != 15) begin : g_bad_width
    $error("cmp_arb: WIDTH must be 15 to match mag15");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RESP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d, rsp_id_q, rsp_id_d, w;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [2:0]         flags_q, flags_d;
  logic               gt, eq, lt, found;

  mag15 u_mag (.a(opa_q), .b(opb_q), .gt(gt), .eq(eq), .lt(lt));

  // First set request scanning upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        w = IDW'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    rsp_id_d = rsp_id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: if (found) begin
        opa_d    = opA[int'(w)*WIDTH +: WIDTH];
        opb_d    = opB[int'(w)*WIDTH +: WIDTH];
        gnt_d    = NUM_REQ'(1) << w;
        rsp_id_d = w;
        state_d  = CMP;
      end
      CMP: begin
        flags_d = {gt, eq, lt};
        state_d = RESP;
      end
      RESP: begin
        ptr_d   = (rsp_id_q == IDW'(NUM_REQ - 1)) ? '0 : rsp_id_q + IDW'(1);
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rsp_id_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rsp_id_q <= rsp_id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      flags_q  <= flags_d;
    end
  end

  assign gnt    = gnt_q;
  assign busy   = state_q != IDLE;
  assign vld    = state_q == RESP;
  assign rsp_id = rsp_id_q;
  assign {AgtB, AeqB, AltB} = flags_q;

`ifdef CMP_ARB_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb cnt_d = (vld && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign cmp_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_cmp_arb.sv
// tb_cmp_arb: directed scoreboard bench for cmp_arb; a negedge monitor checks every vld against queued expectations.
module tb_cmp_arb;
  localparam logic [2:0] GT = 3'b100, EQ = 3'b010, LT = 3'b001;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] f;
  } exp_t;

  logic        clk = 1'b0, rst_n;
  logic [3:0]  req, gnt;
  logic [59:0] opA, opB;
  logic        busy, vld, agtb, aeqb, altb;
  logic [1:0]  rsp_id;
`ifdef CMP_ARB_STATS_EN
  logic [15:0] cmp_cnt;
`endif

  exp_t sb[$];
  exp_t e;
  int   tests = 0, fails = 0, cyc = 0, nvld = 0;

  cmp_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req), .opA(opA), .opB(opB),
    .gnt(gnt), .busy(busy), .vld(vld), .rsp_id(rsp_id),
`ifdef CMP_ARB_STATS_EN
    .cmp_cnt(cmp_cnt),
`endif
    .AgtB(agtb), .AeqB(aeqb), .AltB(altb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic timeout(input string n);
    tests++;
    fails++;
    $display("FAIL %s timeout got=no_vld exp=vld", n);
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_gnt"}, 32'(gnt), 0);
    chk({n, "_busy"}, 32'(busy), 0);
    chk({n, "_vld"}, 32'(vld), 0);
    chk({n, "_rsp_id"}, 32'(rsp_id), 0);
    chk({n, "_flags"}, 32'({agtb, aeqb, altb}), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) nvld = 0;
    else begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
      if (vld) begin
        nvld++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_vld got=rsp_id%0d exp=none", rsp_id);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("flags", 32'({agtb, aeqb, altb}), 32'(e.f));
          chk("gnt_owner", 32'(gnt), 32'(4'b0001 << e.id));
        end
      end
    end
  end

  // Issue one request, wait for its vld, and drop req during RESP.
  task automatic run1(input logic [3:0] r, input logic [1:0] id, input logic [14:0] a,
                      input logic [14:0] b, input logic [2:0] f, input bit chg);
    bit got = 0;
    opA[int'(id)*15 +: 15] = a;
    opB[int'(id)*15 +: 15] = b;
    sb.push_back('{id: id, f: f});
    req = r;
    for (int c = 0; c < 12 && !got; c++) begin
      @(posedge clk); #1;
      if (chg && busy) opA[int'(id)*15 +: 15] = 15'h7FFF;
      if (vld) got = 1;
    end
    if (!got) timeout("run1");
    req = '0;
  endtask

  initial begin
    logic [14:0] ra [4];
    logic [14:0] rb [4];
    bit got;
    int last;
    ra = '{15'h0005, 15'h0002, 15'h0000, 15'h7FFF};
    rb = '{15'h0003, 15'h0002, 15'h7FFF, 15'h0000};
    rst_n = 1'b0;
    req = '0;
    opA = '0;
    opB = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    rst_n = 1'b1;
    // All requesters held: grants rotate 0,1,2,3,0 every 3 cycles.
    for (int i = 0; i < 4; i++) begin
      opA[i*15 +: 15] = ra[i];
      opB[i*15 +: 15] = rb[i];
    end
    sb.push_back('{id: 2'd0, f: GT});
    sb.push_back('{id: 2'd1, f: EQ});
    sb.push_back('{id: 2'd2, f: LT});
    sb.push_back('{id: 2'd3, f: GT});
    sb.push_back('{id: 2'd0, f: GT});
    req = 4'hF;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(posedge clk); #1;
        if (vld) got = 1;
      end
      if (!got) timeout("rr");
      else if (k > 0) chk("rr_period", 32'(cyc - last), 3);
      last = cyc;
    end
    req = '0;
    run1(4'b0100, 2'd2, 15'h1234, 15'h1233, GT, 0);
    run1(4'b0001, 2'd0, 15'h0000, 15'h0000, EQ, 0);
    run1(4'b1000, 2'd3, 15'h7FFF, 15'h0000, GT, 0);
    run1(4'b0101, 2'd0, 15'h0000, 15'h7FFF, LT, 0);
    run1(4'b0101, 2'd2, 15'h0001, 15'h0001, EQ, 0);
    run1(4'b0001, 2'd0, 15'h0100, 15'h0200, LT, 0);
    run1(4'b0010, 2'd1, 15'h0010, 15'h0010, EQ, 1);
    run1(4'b0011, 2'd0, 15'h4000, 15'h3FFF, GT, 0);
    // Reset while the compare is in flight.
    req = 4'b0100;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      if (busy) got = 1;
    end
    if (!got) timeout("mid_cmp_busy");
    rst_n = 1'b0;
    #1 chk_reset("mid_reset");
    req = '0;
    opA[14:0] = 15'h0007;
    opB[14:0] = 15'h0009;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = 4'b0001;
    sb.push_back('{id: 2'd0, f: LT});
    @(posedge clk); #1;
    chk("post_reset_gnt", 32'(gnt), 32'(4'b0001));
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      if (vld) got = 1;
    end
    if (!got) timeout("post_reset");
    req = '0;
    run1(4'b1111, 2'd1, 15'h0000, 15'h0001, LT, 0);
`ifdef CMP_ARB_STATS_EN
    for (int i = 0; i < 5; i++) run1(4'b0100, 2'd2, 15'(i), 15'h0002, i < 2 ? LT : (i == 2 ? EQ : GT), 0);
    @(posedge clk); #1;
    chk("cmp_cnt", 32'(cmp_cnt), 32'(nvld));
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    for (int i = 0; i < 3; i++) run1(4'b0001, 2'd0, 15'h0003, 15'h0003, EQ, 0);
    @(posedge clk); #1;
    chk("cmp_cnt_sat", 32'(cmp_cnt), 32'h0000FFFF);
`endif
    repeat (4) @(posedge clk);
    #1 chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cmp_arb.md
Name: cmp_arb

Overview:
- Round-robin arbiter and sequencer that shares one mag15 magnitude comparator among NUM_REQ requesters.
- The comparator is 15-bit, unsigned, and combinational; this block wraps it with registered operands and registered result flags.
- Each requester presents an operand pair plus a request, is granted in turn, and receives a single-cycle valid with the AgtB/AeqB/AltB result.
- Sits between the audio-sample datapath blocks (level/threshold compares) and the shared comparator.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 15, operand width; fixed to match mag15 (elaboration error if changed).
- IDW, $clog2(NUM_REQ), width of rsp_id (derived, do not override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request, level-sensitive.
- opA  in  NUM_REQ*WIDTH  flattened A operands; requester i at [i*WIDTH +: WIDTH].
- opB  in  NUM_REQ*WIDTH  flattened B operands, same packing.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- busy  out  1  high whenever state != IDLE.
- vld  out  1  one-cycle result strobe.
- rsp_id  out  IDW  index of the requester owning the current result.
- AgtB  out  1  registered result, A>B.
- AeqB  out  1  registered result, A==B.
- AltB  out  1  registered result, A<B.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, gnt=0, busy=0, vld=0, rsp_id=0, AgtB=AeqB=AltB=0, rr pointer ptr=0.
- State machine: IDLE -> CMP -> RESP -> IDLE. No other states. Undefined encodings return to IDLE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner w is the first set req bit scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - At the clock edge: opA_r/opB_r <= requester w's operands; gnt <= onehot(w); rsp_id <= w; go to CMP.
- CMP:
  - mag15 evaluates opA_r vs opB_r (unsigned).
  - At the clock edge: AgtB/AeqB/AltB <= mag15 outputs; go to RESP.
- RESP:
  - vld=1, combinationally decoded from state, high exactly one cycle.
  - At the clock edge: ptr <= (rsp_id+1) mod NUM_REQ; gnt <= 0; go to IDLE.
- Flag rules:
  - Exactly one of AgtB/AeqB/AltB is high after the first completed compare.
  - Flags and rsp_id hold their last values until the next CMP capture.
  - Consumers sample only when vld=1.
- Latency: a request sampled in IDLE at edge k gives gnt high in cycles k+1..k+2 and vld in cycle k+2. Transaction period is 3 cycles.
- Requests are sampled only in IDLE. req changes while busy are ignored.
- Operands are captured once, at the grant edge; later operand changes do not affect the result.
- A requester wanting one compare must drop req during its RESP cycle (vld & gnt[i]). A held req is re-arbitrated.
- Fairness: with all reqs held, grants rotate 0,1,2,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ transactions.
- Single requester held continuously: granted every 3 cycles.
- Wrap-around: ptr=NUM_REQ-1 with req[0] only set grants 0. ptr after the last index wraps to 0.
- Reset mid-transaction: aborts immediately to reset values. No vld is issued for the aborted compare, and ptr returns to 0.
- Operand edge cases: A=B=0 gives AeqB; 15'h7FFF vs 15'h0000 gives AgtB (no sign interpretation).

Optional Feature:
- Macro: CMP_ARB_STATS_EN.
- With the macro defined:
  - Adds output cmp_cnt [15:0], a count of completed transactions that increments in each RESP cycle.
  - The count saturates at 16'hFFFF and does not wrap.
  - Reset value 0; cleared only by rst_n.
- Without the macro: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-CMP -> gnt=0, vld=0, busy=0, flags=0 immediately. After release with req=4'b0001, gnt=4'b0001 at +1 cycle.
- Single compare: req=4'b0100, opA[2]=15'h1234, opB[2]=15'h1233 -> gnt=4'b0100 for 2 cycles, then vld=1, rsp_id=2, AgtB=1, AeqB=0, AltB=0.
- Round-robin: req=4'b1111 held, distinct operands -> rsp_id sequence 0,1,2,3,0 with vld every 3 cycles and gnt always one-hot.
- Wrap and skip: after a grant to 3, req=4'b0101 -> next grants 0 then 2. After a grant to 2 with req=4'b0001 -> grant 0.
- Operand stability: change opA[1] from 15'h0010 to 15'h7FFF during CMP, with opB[1]=15'h0010 -> result AeqB=1 (captured value used). 15'h0000 vs 15'h7FFF -> AltB=1.
- CMP_ARB_STATS_EN: run 5 transactions -> cmp_cnt=5. Force the counter to 16'hFFFE and run 3 transactions -> cmp_cnt=16'hFFFF.
